// File: rtl/des_test_sequencer_if.sv
// Vector stream and per-lane DES core bus shared by the sequencer and its environment.
// The sequencer side is the slave modport; the environment side is the master modport.
interface des_test_sequencer_if #(
    parameter int LANES = 2
);
    logic                 vec_valid;
    logic                 vec_ready;
    logic [767:0]         vec_keys;
    logic [63:0]          vec_msg;
    logic [63:0]          vec_exp;
    logic                 vec_last;
    logic [LANES-1:0]     core_start;
    logic [LANES*768-1:0] core_keys;
    logic [LANES*64-1:0]  core_msg;
    logic [LANES-1:0]     core_done;
    logic [LANES*64-1:0]  core_result;

    // Environment: supplies vectors and hosts the DES cores.
    modport master (
        output vec_valid, vec_keys, vec_msg, vec_exp, vec_last, core_done, core_result,
        input  vec_ready, core_start, core_keys, core_msg
    );

    modport slave (
        input  vec_valid, vec_keys, vec_msg, vec_exp, vec_last, core_done, core_result,
        output vec_ready, core_start, core_keys, core_msg
    );
endinterface

// File: rtl/des_test_sequencer.sv
// Multi-lane DES self-check sequencer: dispatches vectors to the first idle core,
// checks each result against the expected ciphertext and keeps saturating tallies.
module des_test_sequencer #(
    parameter int LANES   = 2,
    parameter int CNT_W   = 15,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    des_test_sequencer_if.slave bus,
    output logic [CNT_W-1:0]    nb_tests_o,
    output logic [CNT_W-1:0]    nb_correct_o,
    output logic [CNT_W-1:0]    nb_timeout_o,
    output logic                busy_o,
    output logic                finished_o
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int INC_W = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        L_IDLE  = 2'd0,
        L_START = 2'd1,
        L_WAIT  = 2'd2
    } lane_state_e;

    lane_state_e             state_q [LANES];
    logic [TMR_W-1:0]        timer_q [LANES];
    logic [LANES-1:0]        start_q;
    logic [LANES-1:0][767:0] keys_q;
    logic [LANES-1:0][63:0]  msg_q;
    logic [LANES-1:0][63:0]  exp_q;
    logic                    pending_last_q;
    logic                    finished_q;
    logic                    busy_q;
    logic [CNT_W-1:0]        tests_q;
    logic [CNT_W-1:0]        correct_q;
    logic [CNT_W-1:0]        timeout_q;

    logic [LANES-1:0]        idle_s;
    logic [LANES-1:0]        done_evt;
    logic [LANES-1:0]        hit_evt;
    logic [LANES-1:0]        tmo_evt;
    logic [LANES-1:0]        dispatch_sel;
    logic [LANES-1:0]        busy_d;
    logic                    pick_found;
    logic                    handshake;
    logic                    all_idle;
    logic                    clear_ok;

    function automatic logic [INC_W-1:0] popcnt(input logic [LANES-1:0] v);
        logic [INC_W-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + INC_W'(v[i]);
        end
        return n;
    endfunction

    // The carry out of the widened sum flags overflow, since an increment never exceeds LANES.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [INC_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        if (s[CNT_W]) begin
            return '1;
        end else begin
            return s[CNT_W-1:0];
        end
    endfunction

    // Lane status decode and per-lane completion events; done takes priority over the timer.
    always_comb begin
        idle_s   = '0;
        done_evt = '0;
        hit_evt  = '0;
        tmo_evt  = '0;
        for (int i = 0; i < LANES; i++) begin
            idle_s[i] = (state_q[i] == L_IDLE);
            if (state_q[i] == L_WAIT) begin
                if (bus.core_done[i]) begin
                    done_evt[i] = 1'b1;
                    hit_evt[i]  = (bus.core_result[i*64 +: 64] == exp_q[i]);
                end else if (timer_q[i] == TMR_W'(TIMEOUT)) begin
                    tmo_evt[i] = 1'b1;
                end else begin
                    tmo_evt[i] = 1'b0;
                end
            end else begin
                done_evt[i] = 1'b0;
            end
        end
    end

    assign all_idle      = &idle_s;
    assign bus.vec_ready = ~rst & (|idle_s) & ~pending_last_q;
    assign handshake     = bus.vec_valid & bus.vec_ready;
    assign clear_ok      = clear_i & ~busy_q;

    // Lowest-index idle lane takes the accepted vector; next-cycle busy per lane.
    always_comb begin
        dispatch_sel = '0;
        busy_d       = '0;
        pick_found   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            dispatch_sel[i] = handshake & idle_s[i] & ~pick_found;
            pick_found      = pick_found | dispatch_sel[i];
            busy_d[i]       = (~idle_s[i] & ~(done_evt[i] | tmo_evt[i])) | dispatch_sel[i];
        end
    end

    // Per-lane FSM with its start pulse, timer and latched vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= L_IDLE;
                timer_q[i] <= '0;
            end
            start_q <= '0;
            keys_q  <= '0;
            msg_q   <= '0;
            exp_q   <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                case (state_q[i])
                    L_IDLE: begin
                        if (dispatch_sel[i]) begin
                            state_q[i] <= L_START;
                            start_q[i] <= 1'b1;
                            keys_q[i]  <= bus.vec_keys;
                            msg_q[i]   <= bus.vec_msg;
                            exp_q[i]   <= bus.vec_exp;
                        end else begin
                            start_q[i] <= 1'b0;
                        end
                    end
                    L_START: begin
                        state_q[i] <= L_WAIT;
                        start_q[i] <= 1'b0;
                        timer_q[i] <= TMR_W'(1);
                    end
                    L_WAIT: begin
                        start_q[i] <= 1'b0;
                        if (done_evt[i] | tmo_evt[i]) begin
                            state_q[i] <= L_IDLE;
                        end else begin
                            timer_q[i] <= timer_q[i] + TMR_W'(1);
                        end
                    end
                    default: begin
                        state_q[i] <= L_IDLE;
                        start_q[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Tallies, busy and batch-end tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tests_q        <= '0;
            correct_q      <= '0;
            timeout_q      <= '0;
            busy_q         <= 1'b0;
            pending_last_q <= 1'b0;
            finished_q     <= 1'b0;
        end else begin
            busy_q <= |busy_d;
            if (clear_ok) begin
                tests_q   <= '0;
                correct_q <= '0;
                timeout_q <= '0;
            end else begin
                tests_q   <= sat_add(tests_q, popcnt(done_evt | tmo_evt));
                correct_q <= sat_add(correct_q, popcnt(hit_evt));
                timeout_q <= sat_add(timeout_q, popcnt(tmo_evt));
            end
            if (handshake && bus.vec_last) begin
                pending_last_q <= 1'b1;
            end else if (pending_last_q && all_idle) begin
                pending_last_q <= 1'b0;
            end else begin
                pending_last_q <= pending_last_q;
            end
            if (pending_last_q && all_idle) begin
                finished_q <= 1'b1;
            end else if (handshake || clear_ok) begin
                finished_q <= 1'b0;
            end else begin
                finished_q <= finished_q;
            end
        end
    end

    assign bus.core_start = start_q;
    assign bus.core_keys  = keys_q;
    assign bus.core_msg   = msg_q;
    assign nb_tests_o     = tests_q;
    assign nb_correct_o   = correct_q;
    assign nb_timeout_o   = timeout_q;
    assign busy_o         = busy_q;
    assign finished_o     = finished_q;
endmodule

// File: tb/tb_des_test_sequencer.sv
// Bench for des_test_sequencer: stand-in DES cores with programmable latency, a table of
// single-vector batches, hand-written multi-cycle sequences and a randomized tally model.
module tb_des_test_sequencer;
    localparam int LANES   = 2;
    localparam int CNT_W   = 5;
    localparam int TIMEOUT = 64;
    localparam int MAXC    = (1 << CNT_W) - 1;

    localparam logic [63:0]  FIPS_PT = 64'h0123456789ABCDEF;
    localparam logic [63:0]  FIPS_CT = 64'h85E813540F0AB405;
    localparam logic [63:0]  M2      = 64'h1122334455667788;
    localparam logic [767:0] FIPS_KEYS = {
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FAD1BA, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic [CNT_W-1:0] nb_tests;
    logic [CNT_W-1:0] nb_correct;
    logic [CNT_W-1:0] nb_timeout;
    logic             busy;
    logic             finished;

    des_test_sequencer_if #(.LANES(LANES)) bus ();

    des_test_sequencer #(.LANES(LANES), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .bus          (bus),
        .nb_tests_o   (nb_tests),
        .nb_correct_o (nb_correct),
        .nb_timeout_o (nb_timeout),
        .busy_o       (busy),
        .finished_o   (finished)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    // Per-lane core latency: -1 never answers, 0 derives it from the message, >0 fixed.
    int lat_ovr [LANES];
    int cnt     [LANES];

    typedef struct {
        logic [63:0]      msg;
        logic [63:0]      exp;
        int               lat;
        logic [CNT_W-1:0] want_ok;
        logic [CNT_W-1:0] want_to;
    } vec_t;
    vec_t tbl [6];

    logic [767:0] rk;
    logic [63:0]  rm;
    logic [63:0]  re;
    int           rl;
    int           m_tests;
    int           m_ok;
    int           m_to;
    int           wn;

    // Stand-in DES core: the FIPS plaintext maps to the FIPS ciphertext, anything else is mixed.
    function automatic logic [63:0] core_fn(input logic [767:0] k, input logic [63:0] m);
        if (m == FIPS_PT) return FIPS_CT;
        return {m[31:0], m[63:32]} ^ k[63:0] ^ k[767:704];
    endfunction

    function automatic int msg_lat(input logic [63:0] m);
        return int'(m[7:0]) % 80;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents a vector, waits (bounded) for ready, returns at the negedge of the lane START cycle.
    task automatic send(input logic [767:0] k, input logic [63:0] m, input logic [63:0] e,
                        input logic last);
        int n;
        n = 0;
        bus.vec_keys  = k;
        bus.vec_msg   = m;
        bus.vec_exp   = e;
        bus.vec_last  = last;
        bus.vec_valid = 1'b1;
        while (bus.vec_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 64'(bus.vec_ready), 64'd1);
        @(negedge clk);
        bus.vec_valid = 1'b0;
        bus.vec_last  = 1'b0;
    endtask

    task automatic wait_fin();
        int n;
        n = 0;
        while (finished !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("finished", 64'(finished), 64'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Core responder: done pulses one cycle, L cycles after the start pulse was seen.
    initial begin
        bus.core_done   = '0;
        bus.core_result = '0;
        for (int i = 0; i < LANES; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < LANES; i++) begin
                bus.core_done[i] = 1'b0;
                if (rst) begin
                    cnt[i] = 0;
                end else begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            bus.core_done[i] = 1'b1;
                            bus.core_result[i*64 +: 64] =
                                core_fn(bus.core_keys[i*768 +: 768], bus.core_msg[i*64 +: 64]);
                        end
                    end
                    if (bus.core_start[i]) begin
                        if (lat_ovr[i] < 0)       cnt[i] = 0;
                        else if (lat_ovr[i] == 0) cnt[i] = msg_lat(bus.core_msg[i*64 +: 64]);
                        else                      cnt[i] = lat_ovr[i];
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{FIPS_PT, FIPS_CT,          17, 5'd1, 5'd0};
        tbl[1] = '{FIPS_PT, 64'h85E813540F0AB404, 17, 5'd0, 5'd0};
        tbl[2] = '{M2, core_fn(FIPS_KEYS, M2), 1,  5'd1, 5'd0};
        tbl[3] = '{M2, core_fn(FIPS_KEYS, M2), 64, 5'd1, 5'd0};
        tbl[4] = '{M2, core_fn(FIPS_KEYS, M2), 65, 5'd0, 5'd1};
        tbl[5] = '{M2, core_fn(FIPS_KEYS, M2), -1, 5'd0, 5'd1};
        for (int i = 0; i < LANES; i++) lat_ovr[i] = 17;
        bus.vec_valid = 1'b0;
        bus.vec_last  = 1'b0;
        bus.vec_keys  = '0;
        bus.vec_msg   = '0;
        bus.vec_exp   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.vec_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fin", 64'(finished), 64'd0);
        chk("rst_tests", 64'(nb_tests), 64'd0);
        chk("rst_start", 64'(bus.core_start), 64'd0);
        chk("rst_keys", 64'(|bus.core_keys), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(bus.vec_ready), 64'd1);
        @(negedge clk);

        // Table of single-vector batches on lane 0
        for (int k = 0; k < 6; k++) begin
            do_clear();
            chk($sformatf("t%0d_clr_tests", k), 64'(nb_tests), 64'd0);
            chk($sformatf("t%0d_clr_fin", k), 64'(finished), 64'd0);
            lat_ovr[0] = tbl[k].lat;
            send(FIPS_KEYS, tbl[k].msg, tbl[k].exp, 1'b1);
            chk($sformatf("t%0d_start", k), 64'(bus.core_start), 64'd1);
            chk($sformatf("t%0d_msg", k), bus.core_msg[63:0], tbl[k].msg);
            @(negedge clk);
            chk($sformatf("t%0d_start_once", k), 64'(bus.core_start), 64'd0);
            wait_fin();
            chk($sformatf("t%0d_tests", k), 64'(nb_tests), 64'd1);
            chk($sformatf("t%0d_correct", k), 64'(nb_correct), 64'(tbl[k].want_ok));
            chk($sformatf("t%0d_timeout", k), 64'(nb_timeout), 64'(tbl[k].want_to));
        end

        // Exact timeout instant, then the lane takes the next vector
        do_clear();
        lat_ovr[0] = -1;
        send(FIPS_KEYS, M2, 64'd0, 1'b1);
        repeat (64) @(negedge clk);
        chk("tmo_early", 64'(nb_timeout), 64'd0);
        @(negedge clk);
        chk("tmo_exact", 64'(nb_timeout), 64'd1);
        lat_ovr[0] = 17;
        send(FIPS_KEYS, FIPS_PT, FIPS_CT, 1'b1);
        chk("tmo_next_start", 64'(bus.core_start), 64'd1);
        wait_fin();
        chk("tmo_tests", 64'(nb_tests), 64'd2);
        chk("tmo_correct", 64'(nb_correct), 64'd1);
        chk("tmo_timeout", 64'(nb_timeout), 64'd1);

        // Parallel dispatch on both lanes
        do_clear();
        lat_ovr[0] = 17;
        lat_ovr[1] = 17;
        send(FIPS_KEYS, FIPS_PT, FIPS_CT, 1'b0);
        chk("par_start0", 64'(bus.core_start), 64'd1);
        send(FIPS_KEYS, FIPS_PT, FIPS_CT, 1'b0);
        chk("par_start1", 64'(bus.core_start), 64'd2);
        @(negedge clk);
        chk("par_ready_low", 64'(bus.vec_ready), 64'd0);
        send(FIPS_KEYS, FIPS_PT, FIPS_CT, 1'b0);
        send(FIPS_KEYS, FIPS_PT, FIPS_CT, 1'b1);
        wait_fin();
        chk("par_tests", 64'(nb_tests), 64'd4);
        chk("par_correct", 64'(nb_correct), 64'd4);

        // Both lanes complete on the same edge
        do_clear();
        lat_ovr[0] = 18;
        lat_ovr[1] = 17;
        send(FIPS_KEYS, FIPS_PT, FIPS_CT, 1'b0);
        send(FIPS_KEYS, FIPS_PT, FIPS_CT, 1'b1);
        wn = 0;
        while (nb_tests == '0 && wn < 200) begin
            @(negedge clk);
            wn++;
        end
        chk("simul_step", 64'(nb_tests), 64'd2);
        wait_fin();
        chk("simul_correct", 64'(nb_correct), 64'd2);

        // Accept clears finished; clear while busy is ignored
        lat_ovr[0] = 17;
        lat_ovr[1] = 17;
        send(FIPS_KEYS, FIPS_PT, FIPS_CT, 1'b1);
        chk("fin_drop", 64'(finished), 64'd0);
        @(negedge clk);
        chk("busy_high", 64'(busy), 64'd1);
        do_clear();
        chk("clr_while_busy", 64'(nb_tests), 64'd2);
        wait_fin();
        chk("after_busy_clr", 64'(nb_tests), 64'd3);

        // Asynchronous reset during WAIT
        lat_ovr[0] = -1;
        send(FIPS_KEYS, M2, 64'd0, 1'b1);
        repeat (5) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_start", 64'(bus.core_start), 64'd0);
        chk("mid_rst_keys", 64'(|bus.core_keys), 64'd0);
        chk("mid_rst_msg", 64'(|bus.core_msg), 64'd0);
        chk("mid_rst_tests", 64'(nb_tests), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(bus.vec_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_pending_lost", 64'(bus.vec_ready), 64'd1);
        @(negedge clk);
        lat_ovr[0] = 17;
        send(FIPS_KEYS, FIPS_PT, FIPS_CT, 1'b1);
        wait_fin();
        chk("post_rst_tests", 64'(nb_tests), 64'd1);
        chk("post_rst_correct", 64'(nb_correct), 64'd1);

        // Randomized batches against a saturating tally model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < LANES; i++) lat_ovr[i] = 0;
        m_tests = 0;
        m_ok    = 0;
        m_to    = 0;
        for (int n = 0; n < 60; n++) begin
            for (int w = 0; w < 24; w++) rk[w*32 +: 32] = $urandom;
            rm = {$urandom, $urandom};
            re = ($urandom_range(0, 1) == 1) ? core_fn(rk, rm) : {$urandom, $urandom};
            rl = msg_lat(rm);
            if (m_tests < MAXC) m_tests++;
            if (rl == 0 || rl > TIMEOUT) begin
                if (m_to < MAXC) m_to++;
            end else if (re == core_fn(rk, rm)) begin
                if (m_ok < MAXC) m_ok++;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(rk, rm, re, (n % 10) == 9);
            if ((n % 10) == 9) begin
                wait_fin();
                chk($sformatf("rnd%0d_tests", n), 64'(nb_tests), 64'(m_tests));
                chk($sformatf("rnd%0d_correct", n), 64'(nb_correct), 64'(m_ok));
                chk($sformatf("rnd%0d_timeout", n), 64'(nb_timeout), 64'(m_to));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/des_test_sequencer.md
# des_test_sequencer

Synthesizable multi-lane self-checking sequencer for DES encryption cores. It accepts test vectors (round keys, plaintext, expected ciphertext) over a valid/ready stream and dispatches each vector to the first idle of LANES external DES cores. It then collects each result, compares it to the expected ciphertext, and keeps pass, test and timeout tallies. It moves vector-file checking from simulation into hardware for on-board regression of the DES datapath.

## Interface
- LANES, 2: number of DES cores driven, 1..8.
- CNT_W, 15: width of tally counters.
- TIMEOUT, 64: maximum cycles a lane waits for done after its start pulse, at least 2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- clear  in  1  synchronous clear of tallies and finished; ignored while busy.
- vec_valid  in  1  vector present.
- vec_ready  out  1  sequencer accepts the vector this cycle.
- vec_keys  in  768  16 round keys; bit 767 = key bit 1 of round 1.
- vec_msg  in  64  plaintext; bit 63 = DES bit 1.
- vec_exp  in  64  expected ciphertext; same ordering.
- vec_last  in  1  marks the final vector of a batch.
- core_start  out  LANES  one-cycle start pulse per lane.
- core_keys  out  LANES*768  lane i in slice [i*768 +: 768].
- core_msg  out  LANES*64  lane i in slice [i*64 +: 64].
- core_done  in  LANES  lane result valid while high.
- core_result  in  LANES*64  lane results.
- nb_tests  out  CNT_W  vectors completed, including timeouts.
- nb_correct  out  CNT_W  vectors whose result equals the expected value.
- nb_timeout  out  CNT_W  vectors abandoned on timeout.
- busy  out  1  any lane not IDLE.
- finished  out  1  batch complete, held high.

## Operation
- Per-lane FSM: IDLE -> START -> WAIT -> IDLE.
  - IDLE: lane is free.
  - START: core_start[i]=1 for exactly one cycle.
  - WAIT: lane waits for core_done[i] or for its timer to reach TIMEOUT.
- Dispatch:
  - vec_ready = any lane IDLE and no pending last.
  - On a handshake, the lowest-index IDLE lane latches vec_keys, vec_msg and vec_exp and moves to START.
  - At most one dispatch per cycle.
- Lane registers hold core_keys and core_msg stable from START until the lane's next dispatch.
- Completion in WAIT:
  - If core_done[i]=1, core_result[i] is compared to the latched expected value; the lane counts a test, counts correct on an equal compare, and returns to IDLE.
  - If the timer reaches TIMEOUT first, the lane counts a test and a timeout, no correct, and returns to IDLE.
  - core_done while IDLE or START is ignored.
- Several lanes completing in one cycle all count in that cycle; each counter adds the popcount of the corresponding events.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Batch end:
  - Accepting a vector with vec_last=1 sets pending_last, which forces vec_ready=0.
  - When pending_last=1 and all lanes are IDLE, finished is set and pending_last is cleared.
- finished clears on the next accepted vector or on clear.
- clear while busy=1 has no effect.

## Timing
- Reset values: vec_ready=0 during reset and 1 from the first cycle after deassertion. All other outputs are 0: core_start, core_keys, core_msg, all tallies, busy and finished.
- Handshake at edge t places the lane in START at t+1, so core_start is high in cycle t+1.
- The lane enters WAIT at t+2 and its timer starts at 1. core_done at t+2 is the earliest valid completion.
- Counters update on the edge after the cycle in which core_done is sampled high. The lane returns to IDLE on that same edge and may be re-dispatched in the same cycle.
- A timeout fires on the edge where the timer equals TIMEOUT.
- vec_ready is combinational from lane states and pending_last only; it does not depend on vec_valid.
- busy is registered as the OR of non-IDLE lanes.
- finished rises one edge after the last lane returns to IDLE.
- Reset asserted mid-test aborts all lanes immediately, drops core_start and loses pending_last.

## Test plan
- Single vector: FIPS key 133457799BBCDFF1, plaintext 0123456789ABCDEF, expected 85E813540F0AB405, vec_last=1, model core with 17-cycle latency -> core_start pulses once on lane 0; nb_tests=1, nb_correct=1, finished=1.
- Wrong expected: same vector with expected 85E813540F0AB404 -> nb_tests=1, nb_correct=0, nb_timeout=0.
- Parallel: LANES=2 and 4 back-to-back vectors -> lanes 0 and 1 start in consecutive cycles; vec_ready=0 while both are in WAIT; final tallies are nb_tests=4, nb_correct=4.
- Simultaneous completion: both lanes raise done in the same cycle -> nb_tests increments by 2 on one edge.
- Timeout: core never asserts done, TIMEOUT=64 -> nb_timeout=1 exactly 64 cycles after entry to WAIT; lane accepts the next vector afterwards.
- Reset mid-operation: assert rst during WAIT -> all outputs return to 0 asynchronously; a new batch after release counts from 0.
